// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the MIPS register-write trace buffer: state encoding and entry layout.
package cpu_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } trace_state_e;

   localparam int PC_W = 32;
   localparam int RA_W = 5;
   localparam int RD_W = 32;

   // Entry layout, LSB first: stamp, write data, write address, pc.
   function automatic int entry_w(input int stamp_w);
      return PC_W + RA_W + RD_W + stamp_w;
   endfunction

   function automatic int data_lsb(input int stamp_w);
      return stamp_w;
   endfunction

   function automatic int addr_lsb(input int stamp_w);
      return stamp_w + RD_W;
   endfunction

   function automatic int pc_lsb(input int stamp_w);
      return stamp_w + RD_W + RA_W;
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port trace storage: clocked write, registered synchronous read.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 85
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Register-write trace capture with PC trigger and oldest-first readout.
//   state | meaning
//   IDLE  | waiting for arm; hits ignored
//   ARMED | recording pre-trigger history, watching for trig_pc
//   POST  | recording post-trigger hits until post counter expires
//   DONE  | capture frozen; entries drained through rd_req
module cpu_trace_buffer
   import cpu_trace_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int CH      = 4,
   parameter int STAMP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              pc_in,
   input  logic                     reg_we,
   input  logic [4:0]               reg_waddr,
   input  logic [31:0]              reg_wdata,
   input  logic [5*CH-1:0]          watch_idx,
   input  logic [CH-1:0]            watch_en,
   input  logic                     arm,
   input  logic [31:0]              trig_pc,
   input  logic [$clog2(DEPTH)-1:0] post_count,
   input  logic                     rd_req,
   output logic                     rd_valid,
   output logic [31:0]              rd_pc,
   output logic [4:0]               rd_addr,
   output logic [31:0]              rd_data,
   output logic [STAMP_W-1:0]       rd_stamp,
   output logic                     rd_last,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int EW    = entry_w(STAMP_W);
   localparam int D_LSB = data_lsb(STAMP_W);
   localparam int A_LSB = addr_lsb(STAMP_W);
   localparam int P_LSB = pc_lsb(STAMP_W);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   trace_state_e        state_q, state_d;
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       post_q, post_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       rcnt_q, rcnt_d;
   logic                ovf_q, ovf_d;
   logic                pend_q, pend_d;
   logic                pend_last_q, pend_last_d;
   logic [STAMP_W-1:0]  stamp_q;
   logic                rd_valid_q, rd_last_q;
   logic [31:0]         rd_pc_q, rd_data_q;
   logic [4:0]          rd_addr_q;
   logic [STAMP_W-1:0]  rd_stamp_q;

   logic                match_any, hit, capture, rd_issue;
   logic [CW-1:0]       remain;
   logic [AW-1:0]       raddr;
   logic [EW-1:0]       wentry, rentry;

   // Duplicate channel matches collapse into a single hit.
   always_comb begin
      match_any = 1'b0;
      for (int k = 0; k < CH; k++) begin
         if (watch_en[k] && (watch_idx[5*k +: 5] == reg_waddr)) match_any = 1'b1;
      end
   end

   assign hit     = reg_we && (reg_waddr != 5'd0) && match_any;
   assign capture = hit && ((state_q == ST_ARMED) || (state_q == ST_POST));
   assign remain  = count_q - rcnt_q;
   // Oldest entry sits count positions behind wptr; a full buffer gives count[AW-1:0]==0.
   assign raddr   = wptr_q - count_q[AW-1:0] + rcnt_q[AW-1:0];
   assign wentry  = {pc_in, reg_waddr, reg_wdata, stamp_q};

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      post_d      = post_q;
      count_d     = count_q;
      rcnt_d      = rcnt_q;
      ovf_d       = ovf_q;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      rd_issue    = 1'b0;

      if (capture) begin
         wptr_d = wptr_q + AW'(1);
         if (count_q == FULL) ovf_d = 1'b1;
         else                 count_d = count_q + CW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               wptr_d  = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               rcnt_d  = '0;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (pc_in == trig_pc) begin
               if (post_count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_POST;
                  post_d  = post_count;
               end
            end
         end
         ST_POST: begin
            if (hit) begin
               post_d = post_q - AW'(1);
               if (post_q == AW'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (pend_q && pend_last_q) begin
               state_d = ST_IDLE;
            end else if (rd_req) begin
               if (remain == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  rd_issue    = 1'b1;
                  rcnt_d      = rcnt_q + CW'(1);
                  pend_d      = 1'b1;
                  pend_last_d = (remain == CW'(1));
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         post_q      <= '0;
         count_q     <= '0;
         rcnt_q      <= '0;
         ovf_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         stamp_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_pc_q     <= '0;
         rd_addr_q   <= '0;
         rd_data_q   <= '0;
         rd_stamp_q  <= '0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         post_q      <= post_d;
         count_q     <= count_d;
         rcnt_q      <= rcnt_d;
         ovf_q       <= ovf_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         stamp_q     <= stamp_q + STAMP_W'(1);
         rd_valid_q  <= pend_q;
         rd_last_q   <= pend_q && pend_last_q;
         if (pend_q) begin
            rd_pc_q    <= rentry[P_LSB +: 32];
            rd_addr_q  <= rentry[A_LSB +: 5];
            rd_data_q  <= rentry[D_LSB +: 32];
            rd_stamp_q <= rentry[STAMP_W-1:0];
         end
      end
   end

   trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk     (clk),
      .we_i    (capture),
      .waddr_i (wptr_q),
      .wdata_i (wentry),
      .re_i    (rd_issue),
      .raddr_i (raddr),
      .rdata_o (rentry)
   );

   assign state    = state_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_pc    = rd_pc_q;
   assign rd_addr  = rd_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_stamp = rd_stamp_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: capture, wrap, post-trigger, filtering, corner events, reset.
module tb_cpu_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic [19:0] watch_idx;
   logic [3:0]  watch_en;
   logic        arm;
   logic [31:0] trig_pc;
   logic [3:0]  post_count;
   logic        rd_req;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] rd_stamp;
   logic        rd_last;
   logic [1:0]  state;
   logic [4:0]  count;
   logic        overflow;

   int err   = 0;
   int n_chk = 0;
   logic [15:0] st0, st1, st2;

   cpu_trace_buffer #(.DEPTH(16), .CH(4), .STAMP_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .reg_we     (reg_we),
      .reg_waddr  (reg_waddr),
      .reg_wdata  (reg_wdata),
      .watch_idx  (watch_idx),
      .watch_en   (watch_en),
      .arm        (arm),
      .trig_pc    (trig_pc),
      .post_count (post_count),
      .rd_req     (rd_req),
      .rd_valid   (rd_valid),
      .rd_pc      (rd_pc),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_stamp   (rd_stamp),
      .rd_last    (rd_last),
      .state      (state),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm;
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("arm_state", 64'(state), 64'd1);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
      reg_we    = 1'b1;
      reg_waddr = a;
      reg_wdata = d;
      pc_in     = pc;
      step();
      reg_we    = 1'b0;
      pc_in     = 32'h1000;
   endtask

   task automatic trigger(input logic [3:0] pcnt);
      post_count = pcnt;
      pc_in      = 32'h40;
      step();
      pc_in      = 32'h1000;
   endtask

   task automatic rd1(input string tag, input logic [31:0] d, input logic [31:0] pc,
                      input logic last, output logic [15:0] stamp);
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk({tag, "_lat"}, 64'(rd_valid), 64'd0);
      step();
      chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
      chk({tag, "_data"}, 64'(rd_data), 64'(d));
      chk({tag, "_pc"}, 64'(rd_pc), 64'(pc));
      chk({tag, "_last"}, 64'(rd_last), 64'(last));
      stamp = rd_stamp;
   endtask

   initial begin
      rst_n = 1'b0; pc_in = 32'h1000; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
      watch_idx = '0; watch_en = '0; arm = 1'b0; trig_pc = 32'h40; post_count = '0;
      rd_req = 1'b0;
      #2;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_last", 64'(rd_last), 64'd0);
      chk("rst_data", 64'(rd_data), 64'd0);
      chk("rst_pc", 64'(rd_pc), 64'd0);
      #10 rst_n = 1'b1;
      step();

      // Basic capture on $s0
      watch_idx = {5'd0, 5'd0, 5'd0, 5'd16};
      watch_en  = 4'b0001;
      wr(5'd16, 32'h99, 32'h100);
      chk("idle_hit_count", 64'(count), 64'd0);
      do_arm();
      wr(5'd16, 32'h11, 32'h100);
      wr(5'd16, 32'h22, 32'h104);
      wr(5'd16, 32'h33, 32'h108);
      chk("b_count", 64'(count), 64'd3);
      trigger(4'd0);
      chk("b_done", 64'(state), 64'd3);
      rd1("b0", 32'h11, 32'h100, 1'b0, st0);
      chk("b0_addr", 64'(rd_addr), 64'd16);
      step();
      chk("b_pulse", 64'(rd_valid), 64'd0);
      rd1("b1", 32'h22, 32'h104, 1'b0, st1);
      rd1("b2", 32'h33, 32'h108, 1'b1, st2);
      chk("b_idle", 64'(state), 64'd0);
      chk("b_stamp_gap", 64'(st2 - st1), 64'd1);

      // Wrap and overflow, back-to-back reads
      do_arm();
      for (int i = 1; i <= 20; i++) wr(5'd16, 32'(i), 32'h200 + 32'(4 * i));
      trigger(4'd0);
      chk("w_count", 64'(count), 64'd16);
      chk("w_ovf", 64'(overflow), 64'd1);
      rd_req = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         if (i == 15) rd_req = 1'b0;
         if (i >= 1) begin
            chk("w_vld", 64'(rd_valid), 64'd1);
            chk("w_data", 64'(rd_data), 64'(i + 4));
            chk("w_last", 64'(rd_last), 64'(i == 16));
         end
      end
      chk("w_idle", 64'(state), 64'd0);

      // Post-trigger with arm ignored in POST
      do_arm();
      chk("p_ovf_clr", 64'(overflow), 64'd0);
      wr(5'd16, 32'hA1, 32'h300);
      wr(5'd16, 32'hA2, 32'h304);
      trigger(4'd3);
      chk("p_post", 64'(state), 64'd2);
      wr(5'd16, 32'hB1, 32'h308);
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("p_arm_ign_st", 64'(state), 64'd2);
      chk("p_arm_ign_cnt", 64'(count), 64'd3);
      wr(5'd16, 32'hB2, 32'h30C);
      chk("p_still_post", 64'(state), 64'd2);
      wr(5'd16, 32'hB3, 32'h310);
      chk("p_done", 64'(state), 64'd3);
      wr(5'd16, 32'hB4, 32'h314);
      wr(5'd16, 32'hB5, 32'h318);
      chk("p_count", 64'(count), 64'd5);
      rd1("p0", 32'hA1, 32'h300, 1'b0, st0);
      rd1("p1", 32'hA2, 32'h304, 1'b0, st0);
      rd1("p2", 32'hB1, 32'h308, 1'b0, st0);
      rd1("p3", 32'hB2, 32'h30C, 1'b0, st0);
      rd1("p4", 32'hB3, 32'h310, 1'b1, st0);
      chk("p_idle", 64'(state), 64'd0);

      // Filtering: $0, unwatched $t0, we=0, duplicate channels on $17
      watch_idx = {5'd0, 5'd8, 5'd17, 5'd17};
      watch_en  = 4'b0011;
      do_arm();
      wr(5'd0, 32'hF0, 32'h400);
      wr(5'd8, 32'hF1, 32'h404);
      reg_waddr = 5'd17; reg_wdata = 32'hF2;
      step();
      chk("f_none", 64'(count), 64'd0);
      wr(5'd17, 32'hD1, 32'h408);
      wr(5'd17, 32'hD2, 32'h40C);
      chk("f_dup", 64'(count), 64'd2);
      trigger(4'd0);
      rd1("f0", 32'hD1, 32'h408, 1'b0, st0);
      rd1("f1", 32'hD2, 32'h40C, 1'b1, st0);

      // Hit in trigger cycle, rd_req while ARMED
      watch_idx = {5'd0, 5'd0, 5'd0, 5'd16};
      watch_en  = 4'b0001;
      do_arm();
      rd_req = 1'b1;
      step();
      step();
      rd_req = 1'b0;
      chk("s_rd_armed", 64'(rd_valid), 64'd0);
      chk("s_armed", 64'(state), 64'd1);
      post_count = 4'd2;
      wr(5'd16, 32'hE1, 32'h40);
      chk("s_trig_post", 64'(state), 64'd2);
      chk("s_trig_cnt", 64'(count), 64'd1);
      wr(5'd16, 32'hE2, 32'h500);
      chk("s_no_dec", 64'(state), 64'd2);
      wr(5'd16, 32'hE3, 32'h504);
      chk("s_done", 64'(state), 64'd3);
      rd1("s0", 32'hE1, 32'h40, 1'b0, st0);
      rd1("s1", 32'hE2, 32'h500, 1'b0, st0);
      rd1("s2", 32'hE3, 32'h504, 1'b1, st0);

      // DONE with no entries
      do_arm();
      trigger(4'd0);
      chk("e_done", 64'(state), 64'd3);
      chk("e_count", 64'(count), 64'd0);
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk("e_idle", 64'(state), 64'd0);
      step();
      chk("e_novld", 64'(rd_valid), 64'd0);

      // Reset with a read in flight
      do_arm();
      for (int i = 0; i < 4; i++) wr(5'd16, 32'h60 + 32'(i), 32'h600 + 32'(4 * i));
      trigger(4'd0);
      rd1("r0", 32'h60, 32'h600, 1'b0, st0);
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("r_state", 64'(state), 64'd0);
      chk("r_count", 64'(count), 64'd0);
      chk("r_vld", 64'(rd_valid), 64'd0);
      chk("r_data", 64'(rd_data), 64'd0);
      step();
      chk("r_vld_hold", 64'(rd_valid), 64'd0);
      rst_n = 1'b1;
      step();
      chk("r_idle", 64'(state), 64'd0);

      $display("Result: errors=%0d of %0d checks", err, n_chk);
      $finish;
   end

endmodule
